// File: rtl/fpu_issue.sv
// fpu_issue: FP instruction dispatch in front of the FPU top.
// Each accepted op reserves the result-bus slot that sits its latency in the
// future. The op's destination tag travels in a matching shift pipeline, and
// the FPU result is captured into registered writeback outputs when the slot
// reaches the FPU output.
module fpu_issue #(
   parameter int TAG_W     = 6,
   parameter int LAT_FADD  = 3,
   parameter int LAT_FSUB  = 3,
   parameter int LAT_FMUL  = 3,
   parameter int LAT_FDIV  = 6,
   parameter int LAT_FSQRT = 3,
   parameter int LAT_FTOI  = 1,
   parameter int LAT_ITOF  = 2,
   parameter int LAT_FABS  = 1,
   parameter int MAX_LAT   = 6
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_funct,
   input  logic [TAG_W-1:0] in_rd,
   input  logic [31:0]      in_x1,
   input  logic [31:0]      in_x2,
   output logic [7:0]       fpu_opcode,
   output logic [31:0]      fpu_x1,
   output logic [31:0]      fpu_x2,
   input  logic [31:0]      fpu_y,
   input  logic             fpu_ovf,
   input  logic             fpu_unf,
   input  logic             fpu_out_valid,
   output logic             wb_valid,
   output logic [TAG_W-1:0] wb_rd,
   output logic [31:0]      wb_data,
   output logic             wb_ovf,
   output logic             wb_unf,
   output logic             busy,
   output logic             err
);

   // Wide enough to hold every latency value 0..MAX_LAT.
   localparam int LW    = $clog2(MAX_LAT + 1);
   // Reservation vector padded to a power of two so that indexing it with any
   // value of lat stays in range; slots at or beyond MAX_LAT are never reserved.
   localparam int PAD_W = 1 << LW;

   logic [LW-1:0]                  lat;
   logic                           fire;
   logic [MAX_LAT-1:0]             res_reg;
   logic [MAX_LAT-1:0]             res_next;
   logic [MAX_LAT-1:0][TAG_W-1:0]  tag_reg;
   logic [MAX_LAT-1:0][TAG_W-1:0]  tag_next;
   logic [PAD_W-1:0]               res_pad;

   // Latency of the offered function code.
   always_comb begin
      lat = '0;
      case (in_funct)
         3'd0:    lat = LW'(LAT_FADD);
         3'd1:    lat = LW'(LAT_FSUB);
         3'd2:    lat = LW'(LAT_FMUL);
         3'd3:    lat = LW'(LAT_FDIV);
         3'd4:    lat = LW'(LAT_FSQRT);
         3'd5:    lat = LW'(LAT_FTOI);
         3'd6:    lat = LW'(LAT_ITOF);
         default: lat = LW'(LAT_FABS);
      endcase
   end

   // An op may issue only if its landing slot is free. After the next shift,
   // slot lat-1 is fed from slot lat, so slot lat is the one to check.
   assign res_pad    = PAD_W'(res_reg);
   assign in_ready   = ~rst & ~res_pad[lat];
   assign fire       = in_valid & in_ready;
   assign fpu_opcode = fire ? (8'd1 << in_funct) : 8'd0;
   assign fpu_x1     = in_x1;
   assign fpu_x2     = in_x2;
   assign busy       = |res_reg;

   // Shift the reservation and tag pipelines down one slot per cycle and
   // insert a newly issued op at slot lat-1.
   generate
      for (genvar gi = 0; gi < MAX_LAT; gi++) begin : g_slot
         logic hit;
         assign hit = fire && (lat == LW'(gi + 1));
         if (gi == MAX_LAT - 1) begin : g_top
            assign res_next[gi] = hit;
            assign tag_next[gi] = hit ? in_rd : '0;
         end else begin : g_mid
            assign res_next[gi] = res_reg[gi+1] | hit;
            assign tag_next[gi] = hit ? in_rd : tag_reg[gi+1];
         end
      end
   endgenerate

   // Reservation and tag pipeline registers.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         res_reg <= '0;
         tag_reg <= '0;
      end else begin
         res_reg <= res_next;
         tag_reg <= tag_next;
      end
   end

   // Registered writeback. Tag and data update only when a reserved result
   // lands, so both hold their previous value while wb_valid is low.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         wb_ovf   <= 1'b0;
         wb_unf   <= 1'b0;
      end else begin
         wb_valid <= res_reg[0];
         wb_ovf   <= res_reg[0] & fpu_ovf;
         wb_unf   <= res_reg[0] & fpu_unf;
         if (res_reg[0]) begin
            wb_rd   <= tag_reg[0];
            wb_data <= fpu_y;
         end
      end
   end

   // Sticky flag: the FPU result-valid disagrees with the expected slot.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (res_reg[0] != fpu_out_valid) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: a stub FPU returns bench-chosen results after the
// bench's own latency table. Expected writebacks go into a scoreboard queue
// when an op is driven and are compared when wb_valid appears.
module tb_fpu_issue;

   localparam int TAG_W = 6;

   logic             sys_clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       in_funct = '0;
   logic [TAG_W-1:0] in_rd = '0;
   logic [31:0]      in_x1 = '0;
   logic [31:0]      in_x2 = '0;
   logic [7:0]       fpu_opcode;
   logic [31:0]      fpu_x1, fpu_x2, fpu_y;
   logic             fpu_ovf, fpu_unf, fpu_out_valid;
   logic             wb_valid;
   logic [TAG_W-1:0] wb_rd;
   logic [31:0]      wb_data;
   logic             wb_ovf, wb_unf, busy, err;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [TAG_W-1:0] rd;
      logic [31:0]      data;
      logic             ovf;
      logic             unf;
   } wb_t;
   wb_t sb_q[$];

   // Stub FPU state
   logic [31:0] mdl_y = '0;
   logic        mdl_ovf = 1'b0, mdl_unf = 1'b0;
   logic [7:0]  stub_v = '0;
   logic [31:0] stub_y [8] = '{default: '0};
   logic        stub_o [8] = '{default: 1'b0};
   logic        stub_u [8] = '{default: 1'b0};
   logic        force_ov = 1'b0;
   logic        stray_ovf = 1'b0;

   fpu_issue dut (
      .sys_clk(sys_clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct), .in_rd(in_rd),
      .in_x1(in_x1), .in_x2(in_x2),
      .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
      .fpu_y(fpu_y), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf), .fpu_out_valid(fpu_out_valid),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_ovf(wb_ovf), .wb_unf(wb_unf), .busy(busy), .err(err)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic int lat_of(input logic [7:0] oh);
      case (oh)
         8'h01, 8'h02, 8'h04, 8'h10: return 3;
         8'h08:                      return 6;
         8'h20, 8'h80:               return 1;
         8'h40:                      return 2;
         default:                    return 0;
      endcase
   endfunction

   // Stub FPU: an op seen on the opcode bus emerges lat_of() cycles later.
   always @(posedge sys_clk) begin
      for (int k = 0; k < 7; k++) begin
         stub_y[k] <= stub_y[k+1];
         stub_o[k] <= stub_o[k+1];
         stub_u[k] <= stub_u[k+1];
      end
      if (lat_of(fpu_opcode) > 0) begin
         stub_v <= {1'b0, stub_v[7:1]} | (8'd1 << (lat_of(fpu_opcode) - 1));
         stub_y[lat_of(fpu_opcode)-1] <= mdl_y;
         stub_o[lat_of(fpu_opcode)-1] <= mdl_ovf;
         stub_u[lat_of(fpu_opcode)-1] <= mdl_unf;
      end else begin
         stub_v <= {1'b0, stub_v[7:1]};
      end
   end

   assign fpu_out_valid = stub_v[0] | force_ov;
   assign fpu_y         = stub_y[0];
   assign fpu_ovf       = (stub_v[0] & stub_o[0]) | stray_ovf;
   assign fpu_unf       = stub_v[0] & stub_u[0];

   // Scoreboard: every writeback must match the oldest expected entry.
   always @(negedge sys_clk) begin
      if (!rst && wb_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", wb_rd, wb_data);
         end else begin
            wb_t e;
            e = sb_q.pop_front();
            if (wb_rd !== e.rd || wb_data !== e.data || wb_ovf !== e.ovf || wb_unf !== e.unf) begin
               failures++;
               $display("FAIL wb_scoreboard: got rd=%0d data=%h ovf=%b unf=%b, required rd=%0d data=%h ovf=%b unf=%b",
                        wb_rd, wb_data, wb_ovf, wb_unf, e.rd, e.data, e.ovf, e.unf);
            end
         end
      end
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   // Offer one op and set what the stub FPU will return for it.
   task automatic drive_op(input logic [2:0] f, input logic [TAG_W-1:0] rd,
                           input logic [31:0] x1, input logic [31:0] x2,
                           input logic [31:0] y, input logic ovf, input logic unf,
                           input bit push);
      in_valid = 1'b1; in_funct = f; in_rd = rd; in_x1 = x1; in_x2 = x2;
      mdl_y = y; mdl_ovf = ovf; mdl_unf = unf;
      if (push) sb_q.push_back('{rd: rd, data: y, ovf: ovf, unf: unf});
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_funct = 3'd0;
      @(posedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (in_ready !== 1'b0 || fpu_opcode !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got ready=%b opcode=%h busy=%b err=%b, required 0 00 0 0",
                  in_ready, fpu_opcode, busy, err);
      end
      checks++;
      if (wb_valid !== 1'b0 || wb_rd !== '0 || wb_data !== 32'h0 || wb_ovf !== 1'b0 || wb_unf !== 1'b0) begin
         failures++;
         $display("FAIL reset_wb: got v=%b rd=%0d data=%h ovf=%b unf=%b, required all 0",
                  wb_valid, wb_rd, wb_data, wb_ovf, wb_unf);
      end
      step();
      in_valid = 1'b0; rst = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got ready=%b busy=%b, required 1 0", in_ready, busy);
      end
   endtask

   task automatic test_fadd();
      step();
      drive_op(3'd0, 6'd5, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b1);
      @(negedge sys_clk);
      checks++;
      if (in_ready !== 1'b1 || fpu_opcode !== 8'h01 || fpu_x1 !== 32'h3F800000 ||
          fpu_x2 !== 32'h40000000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL fadd_issue: got ready=%b opcode=%h x1=%h x2=%h busy=%b, required 1 01 3f800000 40000000 0",
                  in_ready, fpu_opcode, fpu_x1, fpu_x2, busy);
      end
      step(); in_valid = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL fadd_busy_t1: got busy=%b, required 1", busy);
      end
      step(); step();
      @(negedge sys_clk);
      checks++;
      if (busy !== 1'b1 || wb_valid !== 1'b0) begin
         failures++;
         $display("FAIL fadd_t3: got busy=%b wb_valid=%b, required 1 0", busy, wb_valid);
      end
      step();
      @(negedge sys_clk);
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 6'd5 || wb_data !== 32'h40400000 || busy !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL fadd_wb_t4: got v=%b rd=%0d data=%h busy=%b err=%b, required 1 5 40400000 0 0",
                  wb_valid, wb_rd, wb_data, busy, err);
      end
      step();
      @(negedge sys_clk);
      checks++;
      if (wb_valid !== 1'b0 || wb_rd !== 6'd5 || wb_data !== 32'h40400000) begin
         failures++;
         $display("FAIL fadd_hold: got v=%b rd=%0d data=%h, required 0 5 40400000", wb_valid, wb_rd, wb_data);
      end
   endtask

   task automatic test_collision();
      step();
      drive_op(3'd3, 6'd1, 32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0, 1'b0, 1'b1);
      @(negedge sys_clk);
      checks++;
      if (fpu_opcode !== 8'h08) begin
         failures++;
         $display("FAIL fdiv_opcode: got %h, required 08", fpu_opcode);
      end
      step(); in_valid = 1'b0;
      step(); step();
      // t+3: a short op (fabs) is free, fadd collides with the fdiv slot
      in_funct = 3'd7;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL stall_fabs_ready: got %b, required 1", in_ready);
      end
      drive_op(3'd0, 6'd2, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1'b1);
      @(negedge sys_clk);
      checks++;
      if (in_ready !== 1'b0 || fpu_opcode !== 8'h00) begin
         failures++;
         $display("FAIL stall_t3: got ready=%b opcode=%h, required 0 00", in_ready, fpu_opcode);
      end
      step();
      @(negedge sys_clk);
      checks++;
      if (in_ready !== 1'b1 || fpu_opcode !== 8'h01) begin
         failures++;
         $display("FAIL stall_fire_t4: got ready=%b opcode=%h, required 1 01", in_ready, fpu_opcode);
      end
      step(); in_valid = 1'b0;
      step(); step();
      @(negedge sys_clk);
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 6'd1) begin
         failures++;
         $display("FAIL coll_wb_t7: got v=%b rd=%0d, required 1 1", wb_valid, wb_rd);
      end
      step();
      @(negedge sys_clk);
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 6'd2 || err !== 1'b0) begin
         failures++;
         $display("FAIL coll_wb_t8: got v=%b rd=%0d err=%b, required 1 2 0", wb_valid, wb_rd, err);
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 11; c++) begin
         step();
         if (c < 6)
            drive_op(3'd2, 6'(c), 32'h40000000, 32'h3F800000 + c, 32'h40000000 + c, 1'b0, 1'b0, 1'b1);
         else
            in_valid = 1'b0;
         @(negedge sys_clk);
         if (c < 6) begin
            checks++;
            if (in_ready !== 1'b1 || fpu_opcode !== 8'h04) begin
               failures++;
               $display("FAIL b2b_ready c=%0d: got ready=%b opcode=%h, required 1 04", c, in_ready, fpu_opcode);
            end
         end
         checks++;
         if (c >= 4 && c <= 9) begin
            if (wb_valid !== 1'b1 || wb_rd !== 6'(c - 4)) begin
               failures++;
               $display("FAIL b2b_wb c=%0d: got v=%b rd=%0d, required 1 %0d", c, wb_valid, wb_rd, c - 4);
            end
         end else if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle c=%0d: got v=%b, required 0", c, wb_valid);
         end
      end
   endtask

   task automatic test_ftoi_itof();
      step();
      drive_op(3'd5, 6'd9, 32'h40490FDB, 32'h0, 32'h00000003, 1'b0, 1'b0, 1'b1);
      @(negedge sys_clk);
      checks++;
      if (fpu_opcode !== 8'h20) begin
         failures++;
         $display("FAIL ftoi_opcode: got %h, required 20", fpu_opcode);
      end
      step();
      drive_op(3'd6, 6'd10, 32'h00000003, 32'h0, 32'h40400000, 1'b0, 1'b0, 1'b1);
      @(negedge sys_clk);
      checks++;
      if (in_ready !== 1'b1 || fpu_opcode !== 8'h40) begin
         failures++;
         $display("FAIL itof_issue: got ready=%b opcode=%h, required 1 40", in_ready, fpu_opcode);
      end
      step(); in_valid = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 6'd9 || wb_data !== 32'h00000003) begin
         failures++;
         $display("FAIL ftoi_wb_t2: got v=%b rd=%0d data=%h, required 1 9 00000003", wb_valid, wb_rd, wb_data);
      end
      step(); step();
      @(negedge sys_clk);
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 6'd10 || wb_data !== 32'h40400000) begin
         failures++;
         $display("FAIL itof_wb_t4: got v=%b rd=%0d data=%h, required 1 10 40400000", wb_valid, wb_rd, wb_data);
      end
   endtask

   task automatic test_ovf();
      step();
      drive_op(3'd2, 6'd3, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 1'b1);
      step(); in_valid = 1'b0;
      step(); step();
      drive_op(3'd7, 6'd4, 32'hBF800000, 32'h0, 32'h3F800000, 1'b0, 1'b0, 1'b1);
      step(); in_valid = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 6'd3 || wb_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_wb: got v=%b rd=%0d ovf=%b, required 1 3 1", wb_valid, wb_rd, wb_ovf);
      end
      step();
      @(negedge sys_clk);
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 6'd4 || wb_ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_next_wb: got v=%b rd=%0d ovf=%b, required 1 4 0", wb_valid, wb_rd, wb_ovf);
      end
      step(); stray_ovf = 1'b1;
      step(); stray_ovf = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (wb_ovf !== 1'b0 || wb_valid !== 1'b0) begin
         failures++;
         $display("FAIL ovf_masked: got ovf=%b v=%b, required 0 0", wb_ovf, wb_valid);
      end
   endtask

   task automatic test_reset_mid();
      step();
      drive_op(3'd4, 6'd7, 32'h40800000, 32'h0, 32'h40000000, 1'b0, 1'b0, 1'b0);
      @(negedge sys_clk);
      checks++;
      if (fpu_opcode !== 8'h10) begin
         failures++;
         $display("FAIL fsqrt_opcode: got %h, required 10", fpu_opcode);
      end
      step();
      rst = 1'b1; in_valid = 1'b1; in_funct = 3'd0;
      @(negedge sys_clk);
      checks++;
      if (in_ready !== 1'b0 || fpu_opcode !== 8'h00 || busy !== 1'b0 || err !== 1'b0 ||
          wb_valid !== 1'b0 || wb_rd !== '0 || wb_data !== 32'h0 || wb_ovf !== 1'b0 || wb_unf !== 1'b0) begin
         failures++;
         $display("FAIL midrst_outputs: got ready=%b op=%h busy=%b err=%b v=%b rd=%0d data=%h, required all 0",
                  in_ready, fpu_opcode, busy, err, wb_valid, wb_rd, wb_data);
      end
      step();
      step(); rst = 1'b0; in_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge sys_clk);
         checks++;
         if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_wb c=%0d: got v=%b, required 0", c, wb_valid);
         end
         step();
      end
      rst = 1'b1;
      step(); rst = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL midrst_err_clear: got %b, required 0", err);
      end
   endtask

   task automatic test_err();
      step(); force_ov = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL err_before: got %b, required 0", err);
      end
      step(); force_ov = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (err !== 1'b1 || wb_valid !== 1'b0) begin
         failures++;
         $display("FAIL err_set: got err=%b v=%b, required 1 0", err, wb_valid);
      end
      step(); step();
      @(negedge sys_clk);
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky: got %b, required 1", err);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL err_async_clear: got %b, required 0", err);
      end
      step(); rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fadd();
      test_collision();
      test_back_to_back();
      test_ftoi_itof();
      test_ovf();
      test_reset_mid();
      test_err();
      step(); step();
      checks++;
      if (sb_q.size() != 0 || err !== 1'b0) begin
         failures++;
         $display("FAIL final_drain: got pending=%0d err=%b, required 0 0", sb_q.size(), err);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
